// File: rtl/cu_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, state and step
// encodings, instruction classes and the per-class final execute step.
package cu_pkg;

  localparam int                  OPCODE_W = 5;
  localparam logic [OPCODE_W-1:0] ALU_ADD  = 5'b00011;

  localparam logic [OPCODE_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OPCODE_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPCODE_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPCODE_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OPCODE_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OPCODE_W-1:0] OP_ROR  = 5'b00111;
  localparam logic [OPCODE_W-1:0] OP_ROL  = 5'b01000;
  localparam logic [OPCODE_W-1:0] OP_SHR  = 5'b01001;
  localparam logic [OPCODE_W-1:0] OP_SHRA = 5'b01010;
  localparam logic [OPCODE_W-1:0] OP_SHL  = 5'b01011;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPCODE_W-1:0] OP_ANDI = 5'b01101;
  localparam logic [OPCODE_W-1:0] OP_ORI  = 5'b01110;
  localparam logic [OPCODE_W-1:0] OP_DIV  = 5'b01111;
  localparam logic [OPCODE_W-1:0] OP_MUL  = 5'b10000;
  localparam logic [OPCODE_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OPCODE_W-1:0] OP_NOT  = 5'b10010;
  localparam logic [OPCODE_W-1:0] OP_BR   = 5'b10011;
  localparam logic [OPCODE_W-1:0] OP_JR   = 5'b10100;
  localparam logic [OPCODE_W-1:0] OP_JAL  = 5'b10101;
  localparam logic [OPCODE_W-1:0] OP_IN   = 5'b10110;
  localparam logic [OPCODE_W-1:0] OP_OUT  = 5'b10111;
  localparam logic [OPCODE_W-1:0] OP_MFHI = 5'b11000;
  localparam logic [OPCODE_W-1:0] OP_MFLO = 5'b11001;
  localparam logic [OPCODE_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPCODE_W-1:0] OP_HALT = 5'b11011;

  typedef enum logic [1:0] {ST_RESET, ST_EXEC, ST_PAUSE, ST_HALT} state_e;

  typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5, T6, T7} step_e;

  typedef enum logic [4:0] {
    CL_ALU, CL_IMM, CL_LD, CL_LDI, CL_ST, CL_MULDIV, CL_UNARY, CL_BR, CL_JR,
    CL_JAL, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_NOP, CL_HALT, CL_ILLEGAL
  } opclass_e;

  // Step on which an instruction of the given class returns to T0.
  function automatic step_e last_step(input opclass_e c);
    case (c)
      CL_ALU, CL_IMM, CL_LDI:  return T5;
      CL_LD, CL_ST:            return T7;
      CL_MULDIV, CL_BR:        return T6;
      CL_UNARY, CL_JAL:        return T4;
      default:                 return T3;
    endcase
  endfunction

endpackage

// File: rtl/cu_opclass_decode.sv
// Combinational opcode classifier: maps IR[31:27] onto the instruction class
// that selects the execute-phase control pattern.
module cu_opclass_decode
  import cu_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output opclass_e            opclass
);

  always_comb begin
    opclass = CL_ILLEGAL;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
      OP_ROL, OP_SHR, OP_SHRA, OP_SHL:       opclass = CL_ALU;
      OP_ADDI, OP_ANDI, OP_ORI:              opclass = CL_IMM;
      OP_LD:                                 opclass = CL_LD;
      OP_LDI:                                opclass = CL_LDI;
      OP_ST:                                 opclass = CL_ST;
      OP_MUL, OP_DIV:                        opclass = CL_MULDIV;
      OP_NEG, OP_NOT:                        opclass = CL_UNARY;
      OP_BR:                                 opclass = CL_BR;
      OP_JR:                                 opclass = CL_JR;
      OP_JAL:                                opclass = CL_JAL;
      OP_IN:                                 opclass = CL_IN;
      OP_OUT:                                opclass = CL_OUT;
      OP_MFHI:                               opclass = CL_MFHI;
      OP_MFLO:                               opclass = CL_MFLO;
      OP_NOP:                                opclass = CL_NOP;
      OP_HALT:                               opclass = CL_HALT;
      default:                               opclass = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer for the 32-bit bus datapath: state/step registers
// plus output decode from (state, step, instruction class).
module control_unit
  import cu_pkg::*;
(
  input  logic                clk,
  input  logic                clr,
  input  logic [31:0]         IR,
  input  logic                CON_ff,
  input  logic                mem_ready,
  input  logic                stop,
  output logic                Gra,
  output logic                Grb,
  output logic                Grc,
  output logic                Rin,
  output logic                Rout,
  output logic                BAout,
  output logic                Cout,
  output logic                PCin,
  output logic                PCout,
  output logic                IncPC,
  output logic                IRin,
  output logic                MARin,
  output logic                MDRin,
  output logic                MDRout,
  output logic                MDRread,
  output logic                Write,
  output logic                Yin,
  output logic                Zin,
  output logic                ZLOout,
  output logic                ZHIout,
  output logic                HIin,
  output logic                LOin,
  output logic                HIout,
  output logic                LOout,
  output logic                InPortout,
  output logic                OutPortin,
  output logic                CONin,
  output logic [OPCODE_W-1:0] ALU_opcode,
  output logic                run,
  output logic                illegal_op
);

  state_e state_q, state_d;
  step_e  step_q, step_d;
  opclass_e opclass;
  logic [OPCODE_W-1:0] opcode;
  logic wait_now, end_now, halt_now;
  logic unused_ir_bits;

  assign opcode         = IR[31:27];
  assign unused_ir_bits = ^IR[26:0];

  cu_opclass_decode u_decode (
    .opcode  (opcode),
    .opclass (opclass)
  );

  // Steps that stall on the memory handshake; mem_ready is ignored elsewhere.
  assign wait_now = (step_q == T1) ||
                    (opclass == CL_LD && step_q == T6) ||
                    (opclass == CL_ST && step_q == T7);
  assign halt_now = (opclass == CL_HALT) && (step_q == T3);
  assign end_now  = (step_q == last_step(opclass)) && (!wait_now || mem_ready);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_RESET;
      step_q  <= T0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      ST_RESET: begin
        state_d = ST_EXEC;
        step_d  = T0;
      end
      ST_EXEC: begin
        if (halt_now) begin
          state_d = ST_HALT;
          step_d  = T0;
        end else if (end_now) begin
          step_d = T0;
          if (stop) state_d = ST_PAUSE;
        end else if (!wait_now || mem_ready) begin
          step_d = step_e'(step_q + 3'd1);
        end
      end
      ST_PAUSE: begin
        step_d = T0;
        if (!stop) state_d = ST_EXEC;
      end
      default: begin
        state_d = ST_HALT;
        step_d  = T0;
      end
    endcase
  end

  always_comb begin
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
    BAout = 1'b0; Cout = 1'b0; PCin = 1'b0; PCout = 1'b0; IncPC = 1'b0;
    IRin = 1'b0; MARin = 1'b0; MDRin = 1'b0; MDRout = 1'b0; MDRread = 1'b0;
    Write = 1'b0; Yin = 1'b0; Zin = 1'b0; ZLOout = 1'b0; ZHIout = 1'b0;
    HIin = 1'b0; LOin = 1'b0; HIout = 1'b0; LOout = 1'b0; InPortout = 1'b0;
    OutPortin = 1'b0; CONin = 1'b0;
    ALU_opcode = '0;
    illegal_op = 1'b0;
    run        = (state_q == ST_EXEC);

    if (state_q == ST_EXEC) begin
      case (step_q)
        T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
        T1: begin MDRread = 1'b1; MDRin = 1'b1; end
        T2: begin MDRout = 1'b1; IRin = 1'b1; end
        default: begin
          case (opclass)
            CL_ALU, CL_IMM: begin
              if (step_q == T3) begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
              if (step_q == T4) begin
                Zin        = 1'b1;
                ALU_opcode = opcode;
                if (opclass == CL_IMM) Cout = 1'b1;
                else begin Grc = 1'b1; Rout = 1'b1; end
              end
              if (step_q == T5) begin ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            end
            CL_LD, CL_LDI, CL_ST: begin
              if (step_q == T3) begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
              if (step_q == T4) begin Cout = 1'b1; Zin = 1'b1; ALU_opcode = ALU_ADD; end
              if (step_q == T5) begin
                ZLOout = 1'b1;
                if (opclass == CL_LDI) begin Gra = 1'b1; Rin = 1'b1; end
                else MARin = 1'b1;
              end
              if (opclass == CL_LD && step_q == T6) begin MDRread = 1'b1; MDRin = 1'b1; end
              if (opclass == CL_LD && step_q == T7) begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
              if (opclass == CL_ST && step_q == T6) begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
              if (opclass == CL_ST && step_q == T7) Write = 1'b1;
            end
            CL_MULDIV: begin
              if (step_q == T3) begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
              if (step_q == T4) begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; ALU_opcode = opcode; end
              if (step_q == T5) begin ZLOout = 1'b1; LOin = 1'b1; end
              if (step_q == T6) begin ZHIout = 1'b1; HIin = 1'b1; end
            end
            CL_UNARY: begin
              if (step_q == T3) begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; ALU_opcode = opcode; end
              if (step_q == T4) begin ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            end
            CL_BR: begin
              if (step_q == T3) begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
              if (step_q == T4) begin PCout = 1'b1; Yin = 1'b1; end
              if (step_q == T5) begin Cout = 1'b1; Zin = 1'b1; ALU_opcode = ALU_ADD; end
              if (step_q == T6) begin ZLOout = 1'b1; PCin = CON_ff; end
            end
            CL_JR: if (step_q == T3) begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
            CL_JAL: begin
              if (step_q == T3) begin PCout = 1'b1; Grb = 1'b1; Rin = 1'b1; end
              if (step_q == T4) begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
            end
            CL_IN:   if (step_q == T3) begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            CL_OUT:  if (step_q == T3) begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
            CL_MFHI: if (step_q == T3) begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            CL_MFLO: if (step_q == T3) begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            CL_ILLEGAL: if (step_q == T3) illegal_op = 1'b1;
            default: ;
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: each scenario queues per-cycle stimulus and
// the expected control word, then replays the queue and compares every cycle.
module tb_control_unit;

  logic clk, clr, CON_ff, mem_ready, stop;
  logic [31:0] IR;
  logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, PCin, PCout, IncPC, IRin, MARin;
  logic MDRin, MDRout, MDRread, Write, Yin, Zin, ZLOout, ZHIout, HIin, LOin;
  logic HIout, LOout, InPortout, OutPortin, CONin, run, illegal_op;
  logic [4:0] ALU_opcode;
  logic [33:0] obs;

  control_unit dut (
    .clk(clk), .clr(clr), .IR(IR), .CON_ff(CON_ff), .mem_ready(mem_ready), .stop(stop),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout),
    .PCin(PCin), .PCout(PCout), .IncPC(IncPC), .IRin(IRin), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .MDRread(MDRread), .Write(Write), .Yin(Yin), .Zin(Zin),
    .ZLOout(ZLOout), .ZHIout(ZHIout), .HIin(HIin), .LOin(LOin), .HIout(HIout),
    .LOout(LOout), .InPortout(InPortout), .OutPortin(OutPortin), .CONin(CONin),
    .ALU_opcode(ALU_opcode), .run(run), .illegal_op(illegal_op)
  );

  assign obs = {ALU_opcode, illegal_op, run, CONin, OutPortin, InPortout, LOout, HIout,
                LOin, HIin, ZHIout, ZLOout, Zin, Yin, Write, MDRread, MDRout, MDRin,
                MARin, IRin, IncPC, PCout, PCin, Cout, BAout, Rout, Rin, Grc, Grb, Gra};

  localparam logic [33:0] GRA = 34'd1 << 0,  GRB = 34'd1 << 1,  GRC = 34'd1 << 2;
  localparam logic [33:0] RIN = 34'd1 << 3,  ROUT = 34'd1 << 4, BAOUT = 34'd1 << 5;
  localparam logic [33:0] COUT = 34'd1 << 6, PCIN = 34'd1 << 7, PCOUT = 34'd1 << 8;
  localparam logic [33:0] INCPC = 34'd1 << 9, IRIN = 34'd1 << 10, MARIN = 34'd1 << 11;
  localparam logic [33:0] MDRIN = 34'd1 << 12, MDROUT = 34'd1 << 13, MDRREAD = 34'd1 << 14;
  localparam logic [33:0] WRITE = 34'd1 << 15, YIN = 34'd1 << 16, ZIN = 34'd1 << 17;
  localparam logic [33:0] ZLOOUT = 34'd1 << 18, ZHIOUT = 34'd1 << 19, HIIN = 34'd1 << 20;
  localparam logic [33:0] LOIN = 34'd1 << 21, HIOUT = 34'd1 << 22, LOOUT = 34'd1 << 23;
  localparam logic [33:0] INPORTOUT = 34'd1 << 24, OUTPORTIN = 34'd1 << 25, CONIN = 34'd1 << 26;
  localparam logic [33:0] RUN = 34'd1 << 27, ILL = 34'd1 << 28;
  localparam logic [33:0] BUS = ROUT | BAOUT | COUT | PCOUT | MDROUT | ZLOOUT | ZHIOUT |
                                HIOUT | LOOUT | INPORTOUT;

  typedef struct {
    logic [33:0] exp;
    logic [31:0] ir;
    logic        mr;
    logic        stp;
    logic        con;
    string       tag;
  } ent_t;

  ent_t sb[$];
  ent_t cur;
  int n_pass = 0;
  int n_total = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [33:0] alu(input logic [4:0] op);
    return {op, 29'd0};
  endfunction

  function automatic logic [31:0] mk_ir(input logic [4:0] op);
    return {op, 27'h0123456};
  endfunction

  task automatic push(input logic [33:0] exp, input logic [31:0] ir, input logic mr,
                      input logic stp, input logic con, input string tag);
    ent_t e;
    e.exp = exp; e.ir = ir; e.mr = mr; e.stp = stp; e.con = con; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic push_fetch(input logic [31:0] ir, input int waits, input logic stp);
    push(RUN | PCOUT | MARIN | INCPC, ir, 1'b1, stp, 1'b0, "fetch_T0");
    for (int i = 0; i < waits; i++) push(RUN | MDRREAD | MDRIN, ir, 1'b0, stp, 1'b0, "fetch_T1_wait");
    push(RUN | MDRREAD | MDRIN, ir, 1'b1, stp, 1'b0, "fetch_T1");
    push(RUN | MDROUT | IRIN, ir, 1'b1, stp, 1'b0, "fetch_T2");
  endtask

  task automatic test_reset;
    clr = 1'b0; IR = '0; CON_ff = 1'b0; mem_ready = 1'b0; stop = 1'b0;
    repeat (2) @(posedge clk);
    #1; n_total++;
    if (obs !== 34'd0) $display("FAIL reset_outputs: got %h want %h", obs, 34'd0); else n_pass++;
    clr = 1'b1;
    #1; n_total++;
    if (obs !== 34'd0) $display("FAIL reset_release_cycle: got %h want %h", obs, 34'd0); else n_pass++;
    @(posedge clk); #1;
    $display("txn reset released");
  endtask

  task automatic test_fetch_wait;
    push_fetch(mk_ir(5'b11010), 3, 1'b0);
    push(RUN, mk_ir(5'b11010), 1'b1, 1'b0, 1'b0, "nop_T3");
    while (sb.size() != 0) begin
      cur = sb.pop_front();
      IR = cur.ir; mem_ready = cur.mr; stop = cur.stp; CON_ff = cur.con;
      #1; n_total++;
      if (obs !== cur.exp) $display("FAIL %s: got %h want %h", cur.tag, obs, cur.exp); else n_pass++;
      @(posedge clk); #1;
    end
    $display("txn nop with 3-cycle fetch wait");
  endtask

  task automatic test_alu;
    logic [31:0] add_ir, addi_ir;
    add_ir = 32'h18918000; addi_ir = mk_ir(5'b01100);
    push_fetch(add_ir, 0, 1'b0);
    push(RUN | GRB | ROUT | YIN, add_ir, 1'b0, 1'b0, 1'b0, "add_T3");
    push(RUN | GRC | ROUT | ZIN | alu(5'b00011), add_ir, 1'b0, 1'b0, 1'b0, "add_T4");
    push(RUN | ZLOOUT | GRA | RIN, add_ir, 1'b0, 1'b0, 1'b0, "add_T5");
    push_fetch(addi_ir, 1, 1'b0);
    push(RUN | GRB | ROUT | YIN, addi_ir, 1'b1, 1'b0, 1'b0, "addi_T3");
    push(RUN | COUT | ZIN | alu(5'b01100), addi_ir, 1'b1, 1'b0, 1'b0, "addi_T4");
    push(RUN | ZLOOUT | GRA | RIN, addi_ir, 1'b1, 1'b0, 1'b0, "addi_T5");
    while (sb.size() != 0) begin
      cur = sb.pop_front();
      IR = cur.ir; mem_ready = cur.mr; stop = cur.stp; CON_ff = cur.con;
      #1; n_total++;
      if (obs !== cur.exp) $display("FAIL %s: got %h want %h", cur.tag, obs, cur.exp); else n_pass++;
      n_total++;
      if ($countones(obs & BUS) > 1) $display("FAIL bus_excl %s: got %0d drivers want <=1", cur.tag, $countones(obs & BUS));
      else n_pass++;
      @(posedge clk); #1;
    end
    $display("txn add R1,R2,R3 then addi");
  endtask

  task automatic test_branch;
    logic [31:0] br_ir;
    br_ir = mk_ir(5'b10011);
    for (int c = 0; c < 2; c++) begin
      push_fetch(br_ir, 0, 1'b0);
      push(RUN | GRA | ROUT | CONIN, br_ir, 1'b1, 1'b0, c[0], "br_T3");
      push(RUN | PCOUT | YIN, br_ir, 1'b1, 1'b0, c[0], "br_T4");
      push(RUN | COUT | ZIN | alu(5'b00011), br_ir, 1'b1, 1'b0, c[0], "br_T5");
      push(RUN | ZLOOUT | (c == 1 ? PCIN : 34'd0), br_ir, 1'b1, 1'b0, c[0], "br_T6");
    end
    while (sb.size() != 0) begin
      cur = sb.pop_front();
      IR = cur.ir; mem_ready = cur.mr; stop = cur.stp; CON_ff = cur.con;
      #1; n_total++;
      if (obs !== cur.exp) $display("FAIL %s: got %h want %h", cur.tag, obs, cur.exp); else n_pass++;
      @(posedge clk); #1;
    end
    $display("txn brzr CON_ff=0 then CON_ff=1");
  endtask

  task automatic test_store;
    logic [31:0] st_ir;
    st_ir = mk_ir(5'b00010);
    push_fetch(st_ir, 0, 1'b0);
    push(RUN | GRB | BAOUT | YIN, st_ir, 1'b1, 1'b0, 1'b0, "st_T3");
    push(RUN | COUT | ZIN | alu(5'b00011), st_ir, 1'b1, 1'b0, 1'b0, "st_T4");
    push(RUN | ZLOOUT | MARIN, st_ir, 1'b1, 1'b0, 1'b0, "st_T5");
    push(RUN | GRA | ROUT | MDRIN, st_ir, 1'b1, 1'b0, 1'b0, "st_T6");
    push(RUN | WRITE, st_ir, 1'b0, 1'b0, 1'b0, "st_T7_wait1");
    push(RUN | WRITE, st_ir, 1'b0, 1'b0, 1'b0, "st_T7_wait2");
    push(RUN | WRITE, st_ir, 1'b1, 1'b0, 1'b0, "st_T7");
    while (sb.size() != 0) begin
      cur = sb.pop_front();
      IR = cur.ir; mem_ready = cur.mr; stop = cur.stp; CON_ff = cur.con;
      #1; n_total++;
      if (obs !== cur.exp) $display("FAIL %s: got %h want %h", cur.tag, obs, cur.exp); else n_pass++;
      @(posedge clk); #1;
    end
    $display("txn st with 2-cycle write wait");
  endtask

  task automatic test_load_clr;
    logic [31:0] ld_ir;
    ld_ir = mk_ir(5'b00000);
    push_fetch(ld_ir, 0, 1'b0);
    push(RUN | GRB | BAOUT | YIN, ld_ir, 1'b0, 1'b0, 1'b0, "ld_T3");
    push(RUN | COUT | ZIN | alu(5'b00011), ld_ir, 1'b0, 1'b0, 1'b0, "ld_T4");
    push(RUN | ZLOOUT | MARIN, ld_ir, 1'b0, 1'b0, 1'b0, "ld_T5");
    push(RUN | MDRREAD | MDRIN, ld_ir, 1'b0, 1'b0, 1'b0, "ld_T6_wait");
    while (sb.size() != 0) begin
      cur = sb.pop_front();
      IR = cur.ir; mem_ready = cur.mr; stop = cur.stp; CON_ff = cur.con;
      #1; n_total++;
      if (obs !== cur.exp) $display("FAIL %s: got %h want %h", cur.tag, obs, cur.exp); else n_pass++;
      @(posedge clk); #1;
    end
    clr = 1'b0;
    #1; n_total++;
    if (obs !== 34'd0) $display("FAIL clr_async_at_ld_T6: got %h want %h", obs, 34'd0); else n_pass++;
    @(posedge clk); #1; n_total++;
    if (obs !== 34'd0) $display("FAIL clr_held: got %h want %h", obs, 34'd0); else n_pass++;
    clr = 1'b1;
    @(posedge clk); #1;
    push_fetch(ld_ir, 0, 1'b0);
    push(RUN | GRB | BAOUT | YIN, ld_ir, 1'b0, 1'b0, 1'b0, "ld2_T3");
    push(RUN | COUT | ZIN | alu(5'b00011), ld_ir, 1'b0, 1'b0, 1'b0, "ld2_T4");
    push(RUN | ZLOOUT | MARIN, ld_ir, 1'b0, 1'b0, 1'b0, "ld2_T5");
    push(RUN | MDRREAD | MDRIN, ld_ir, 1'b0, 1'b0, 1'b0, "ld2_T6_wait");
    push(RUN | MDRREAD | MDRIN, ld_ir, 1'b1, 1'b0, 1'b0, "ld2_T6");
    push(RUN | MDROUT | GRA | RIN, ld_ir, 1'b0, 1'b0, 1'b0, "ld2_T7");
    while (sb.size() != 0) begin
      cur = sb.pop_front();
      IR = cur.ir; mem_ready = cur.mr; stop = cur.stp; CON_ff = cur.con;
      #1; n_total++;
      if (obs !== cur.exp) $display("FAIL %s: got %h want %h", cur.tag, obs, cur.exp); else n_pass++;
      @(posedge clk); #1;
    end
    $display("txn ld interrupted by clr, then full ld");
  endtask

  task automatic test_misc;
    logic [31:0] mul_ir, jal_ir, neg_ir, mflo_ir;
    mul_ir = mk_ir(5'b10000); jal_ir = mk_ir(5'b10101);
    neg_ir = mk_ir(5'b10001); mflo_ir = mk_ir(5'b11001);
    push_fetch(mul_ir, 0, 1'b0);
    push(RUN | GRA | ROUT | YIN, mul_ir, 1'b1, 1'b0, 1'b0, "mul_T3");
    push(RUN | GRB | ROUT | ZIN | alu(5'b10000), mul_ir, 1'b1, 1'b0, 1'b0, "mul_T4");
    push(RUN | ZLOOUT | LOIN, mul_ir, 1'b1, 1'b0, 1'b0, "mul_T5");
    push(RUN | ZHIOUT | HIIN, mul_ir, 1'b1, 1'b0, 1'b0, "mul_T6");
    push_fetch(jal_ir, 0, 1'b0);
    push(RUN | PCOUT | GRB | RIN, jal_ir, 1'b1, 1'b0, 1'b0, "jal_T3");
    push(RUN | GRA | ROUT | PCIN, jal_ir, 1'b1, 1'b0, 1'b0, "jal_T4");
    push_fetch(neg_ir, 0, 1'b0);
    push(RUN | GRB | ROUT | ZIN | alu(5'b10001), neg_ir, 1'b1, 1'b0, 1'b0, "neg_T3");
    push(RUN | ZLOOUT | GRA | RIN, neg_ir, 1'b1, 1'b0, 1'b0, "neg_T4");
    push_fetch(mflo_ir, 0, 1'b0);
    push(RUN | LOOUT | GRA | RIN, mflo_ir, 1'b1, 1'b0, 1'b0, "mflo_T3");
    while (sb.size() != 0) begin
      cur = sb.pop_front();
      IR = cur.ir; mem_ready = cur.mr; stop = cur.stp; CON_ff = cur.con;
      #1; n_total++;
      if (obs !== cur.exp) $display("FAIL %s: got %h want %h", cur.tag, obs, cur.exp); else n_pass++;
      n_total++;
      if ($countones(obs & BUS) > 1) $display("FAIL bus_excl %s: got %0d drivers want <=1", cur.tag, $countones(obs & BUS));
      else n_pass++;
      @(posedge clk); #1;
    end
    $display("txn mul, jal, neg, mflo");
  endtask

  task automatic test_pause_illegal;
    logic [31:0] nop_ir, bad_ir;
    nop_ir = mk_ir(5'b11010); bad_ir = mk_ir(5'b11111);
    push_fetch(nop_ir, 0, 1'b1);
    push(RUN, nop_ir, 1'b1, 1'b1, 1'b0, "nop_T3_stop");
    push(34'd0, nop_ir, 1'b1, 1'b1, 1'b0, "pause_hold");
    push(34'd0, nop_ir, 1'b1, 1'b0, 1'b0, "pause_exit");
    push_fetch(bad_ir, 0, 1'b0);
    push(RUN | ILL, bad_ir, 1'b1, 1'b0, 1'b0, "illegal_T3");
    push_fetch(nop_ir, 0, 1'b0);
    push(RUN, nop_ir, 1'b1, 1'b0, 1'b0, "nop_after_illegal");
    while (sb.size() != 0) begin
      cur = sb.pop_front();
      IR = cur.ir; mem_ready = cur.mr; stop = cur.stp; CON_ff = cur.con;
      #1; n_total++;
      if (obs !== cur.exp) $display("FAIL %s: got %h want %h", cur.tag, obs, cur.exp); else n_pass++;
      @(posedge clk); #1;
    end
    $display("txn pause after nop, illegal opcode 11111");
  endtask

  task automatic test_halt;
    logic [31:0] halt_ir;
    halt_ir = mk_ir(5'b11011);
    push_fetch(halt_ir, 0, 1'b0);
    push(RUN, halt_ir, 1'b1, 1'b0, 1'b0, "halt_T3");
    for (int i = 0; i < 4; i++) push(34'd0, halt_ir, 1'b1, 1'b0, 1'b1, "halted");
    while (sb.size() != 0) begin
      cur = sb.pop_front();
      IR = cur.ir; mem_ready = cur.mr; stop = cur.stp; CON_ff = cur.con;
      #1; n_total++;
      if (obs !== cur.exp) $display("FAIL %s: got %h want %h", cur.tag, obs, cur.exp); else n_pass++;
      @(posedge clk); #1;
    end
    clr = 1'b0;
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1; n_total++;
    if (obs !== (RUN | PCOUT | MARIN | INCPC))
      $display("FAIL halt_clr_restart: got %h want %h", obs, RUN | PCOUT | MARIN | INCPC);
    else n_pass++;
    $display("txn halt then clr restart");
  endtask

  initial begin
    test_reset();
    test_fetch_wait();
    test_alu();
    test_branch();
    test_store();
    test_load_clr();
    test_misc();
    test_pause_illegal();
    test_halt();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
